// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO controller.
//   fifo_clog2      : ceiling log2, used to derive the RAM address width
//   fifo_ptr_width  : pointer/count width (address bits plus one wrap bit)
//   fifo_pipe_legal : legal range of the RAM read pipeline parameter
package fifo_pkg;

  function automatic int unsigned fifo_clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  // One extra bit so that a count of exactly DEPTH is representable.
  function automatic int unsigned fifo_ptr_width(input int unsigned aw);
    return aw + 1;
  endfunction

  function automatic bit fifo_pipe_legal(input int unsigned pipe);
    return pipe <= 1;
  endfunction

endpackage

// File: rtl/fifo_rd_vld_pipe.sv
// Read-valid delay line: delays the accepted-pop strobe by Stages cycles so it
// lines up with data leaving the RAM.
//   clk_i  : clock
//   rst_ni : asynchronous active-low clear (drops in-flight reads at once)
//   vld_i  : accepted pop this cycle
//   vld_o  : read data valid
module fifo_rd_vld_pipe
  import fifo_pkg::*;
#(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vld_i,
  output logic vld_o
);

  logic [Stages-1:0] sr_q;
  logic [Stages-1:0] sr_d;

  if (Stages == 1) begin : g_one
    assign sr_d = vld_i;
  end else begin : g_multi
    assign sr_d = {sr_q[Stages-2:0], vld_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign vld_o = sr_q[Stages-1];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller driving the address/enable side of an LSRAM
// wrapper. Owns the pointers, occupancy count and status flags, and returns
// RAM read data with a valid strobe aligned to the RAM read latency (1+PIPE).
//   CLOCK, RESET_N         : clock, asynchronous active-low reset
//   WE, DATA               : push request and data
//   RE                     : pop request
//   Q, DVLD                : pop data (straight from RAM_RDATA) and its strobe
//   FULL, EMPTY            : registered status flags
//   AFULL, AEMPTY          : registered threshold flags
//   OVERFLOW, UNDERFLOW    : one-cycle pulses for rejected push/pop
//   WRCNT                  : occupancy count 0..DEPTH
//   RAM_W*, RAM_R*         : RAM wrapper write/read ports
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned AW         = fifo_clog2(DEPTH),
  parameter int unsigned PIPE       = 1,
  parameter int unsigned AFULL_VAL  = 120,
  parameter int unsigned AEMPTY_VAL = 8
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             WE,
  input  logic [WIDTH-1:0] DATA,
  input  logic             RE,
  output logic [WIDTH-1:0] Q,
  output logic             DVLD,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  output logic [AW:0]      WRCNT,
  output logic [WIDTH-1:0] RAM_WDATA,
  output logic [AW-1:0]    RAM_WADDR,
  output logic             RAM_WEN,
  output logic [AW-1:0]    RAM_RADDR,
  output logic             RAM_REN,
  input  logic [WIDTH-1:0] RAM_RDATA
);

  localparam int unsigned PW = fifo_ptr_width(AW);
  localparam logic [PW-1:0] FullCnt   = PW'(DEPTH);
  localparam logic [PW-1:0] AfullCnt  = PW'(AFULL_VAL);
  localparam logic [PW-1:0] AemptyCnt = PW'(AEMPTY_VAL);

  if (!fifo_pipe_legal(PIPE) || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("fifo_sync_ctrl: PIPE must be 0/1 and DEPTH a power of 2 >= 4");
  end

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, empty_q, afull_q, aempty_q;
  logic          ovf_q, udf_q;
  logic          wr_acc, rd_acc;

  assign wr_acc = WE & ~full_q;
  assign rd_acc = RE & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (wr_acc) wptr_d = wptr_q + PW'(1);
    if (rd_acc) rptr_d = rptr_q + PW'(1);
    count_d = count_q + PW'(wr_acc) - PW'(rd_acc);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      // Flags come from the next count so they are exact in the following cycle.
      full_q   <= (count_d == FullCnt);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AfullCnt);
      aempty_q <= (count_d <= AemptyCnt);
      ovf_q    <= WE & full_q;
      udf_q    <= RE & empty_q;
    end
  end

  // Flags are count-based; the wrap bits only keep the pointers self-describing.
  logic unused_wrap;
  assign unused_wrap = wptr_q[PW-1] ^ rptr_q[PW-1];

  fifo_rd_vld_pipe #(
    .Stages (1 + PIPE)
  ) u_rd_vld_pipe (
    .clk_i  (CLOCK),
    .rst_ni (RESET_N),
    .vld_i  (rd_acc),
    .vld_o  (DVLD)
  );

  assign RAM_WEN   = wr_acc;
  assign RAM_WADDR = wptr_q[AW-1:0];
  assign RAM_WDATA = DATA;
  assign RAM_REN   = rd_acc;
  assign RAM_RADDR = rptr_q[AW-1:0];
  assign Q         = RAM_RDATA;

  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign AFULL     = afull_q;
  assign AEMPTY    = aempty_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;
  assign WRCNT     = count_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
module tb_fifo_sync_ctrl;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 128;
  localparam int AW     = 7;
  localparam int AFULLV = 120;
  localparam int AEMPV  = 8;

  logic             CLOCK;
  logic             RESET_N;
  logic             WE, RE;
  logic [WIDTH-1:0] DATA, Q, RAM_WDATA, RAM_RDATA;
  logic             DVLD, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW;
  logic [AW:0]      WRCNT;
  logic [AW-1:0]    RAM_WADDR, RAM_RADDR;
  logic             RAM_WEN, RAM_REN;

  fifo_sync_ctrl #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .PIPE       (1),
    .AFULL_VAL  (AFULLV),
    .AEMPTY_VAL (AEMPV)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .WE        (WE),
    .DATA      (DATA),
    .RE        (RE),
    .Q         (Q),
    .DVLD      (DVLD),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .AFULL     (AFULL),
    .AEMPTY    (AEMPTY),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW),
    .WRCNT     (WRCNT),
    .RAM_WDATA (RAM_WDATA),
    .RAM_WADDR (RAM_WADDR),
    .RAM_WEN   (RAM_WEN),
    .RAM_RADDR (RAM_RADDR),
    .RAM_REN   (RAM_REN),
    .RAM_RDATA (RAM_RDATA)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // LSRAM wrapper stand-in: registered read plus one output pipeline stage.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_r1, ram_r2;
  always_ff @(posedge CLOCK) begin
    if (RAM_WEN) mem[RAM_WADDR] <= RAM_WDATA;
    if (RAM_REN) ram_r1 <= mem[RAM_RADDR];
    ram_r2 <= ram_r1;
  end
  assign RAM_RDATA = ram_r2;

  // Reference model: FIFO contents as a queue, pops due two cycles later.
  logic [WIDTH-1:0] mq[$];
  int               due_cyc[$];
  logic [WIDTH-1:0] due_dat[$];
  int               cyc;
  int               wr_total, rd_total;
  bit               m_ovf, m_udf;
  int               checks, errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    due_cyc.delete();
    due_dat.delete();
    wr_total = 0;
    rd_total = 0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  task automatic check_state(input bit we, input bit re, input logic [WIDTH-1:0] d);
    int  n;
    bit  exp_vld;
    n = mq.size();
    chk("full",      FULL,      n == DEPTH);
    chk("empty",     EMPTY,     n == 0);
    chk("afull",     AFULL,     n >= AFULLV);
    chk("aempty",    AEMPTY,    n <= AEMPV);
    chk("wrcnt",     WRCNT,     n);
    chk("overflow",  OVERFLOW,  m_ovf);
    chk("underflow", UNDERFLOW, m_udf);
    chk("ram_wen",   RAM_WEN,   we && n != DEPTH);
    chk("ram_ren",   RAM_REN,   re && n != 0);
    if (we && n != DEPTH) begin
      chk("ram_waddr", RAM_WADDR, wr_total % DEPTH);
      chk("ram_wdata", RAM_WDATA, d);
    end
    if (re && n != 0) chk("ram_raddr", RAM_RADDR, rd_total % DEPTH);
    exp_vld = (due_cyc.size() > 0) && (due_cyc[0] == cyc);
    chk("dvld", DVLD, exp_vld);
    if (exp_vld) begin
      chk("q", Q, due_dat[0]);
      void'(due_cyc.pop_front());
      void'(due_dat.pop_front());
    end
  endtask

  // One clock cycle: drive just after the rising edge, check on the falling edge.
  task automatic cycle(input bit we, input bit re, input logic [WIDTH-1:0] d);
    bit wr_acc, rd_acc;
    WE   = we;
    RE   = re;
    DATA = d;
    @(negedge CLOCK);
    check_state(we, re, d);
    wr_acc = we && (mq.size() != DEPTH);
    rd_acc = re && (mq.size() != 0);
    m_ovf  = we && (mq.size() == DEPTH);
    m_udf  = re && (mq.size() == 0);
    if (rd_acc) begin
      due_dat.push_back(mq.pop_front());
      due_cyc.push_back(cyc + 2);
      rd_total++;
    end
    if (wr_acc) begin
      mq.push_back(d);
      wr_total++;
    end
    @(posedge CLOCK);
    cyc++;
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    WE      = 1'b0;
    RE      = 1'b0;
    DATA    = '0;
    RESET_N = 1'b1;
    model_clear();
    #3 RESET_N = 1'b0;
    #1;
    chk("rst_empty",  EMPTY,  1'b1);
    chk("rst_aempty", AEMPTY, 1'b1);
    chk("rst_full",   FULL,   1'b0);
    chk("rst_wrcnt",  WRCNT,  0);
    chk("rst_dvld",   DVLD,   1'b0);
    chk("rst_wen",    RAM_WEN, 1'b0);
    chk("rst_ren",    RAM_REN, 1'b0);
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK) RESET_N = 1'b1;
    @(posedge CLOCK);
    #1;

    // Fill with 1..128, then one rejected push.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, 32'(i));
    chk("fill_full",  FULL,  1'b1);
    chk("fill_wrcnt", WRCNT, DEPTH);
    cycle(1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("ovf_pulse", OVERFLOW, 1'b1);
    chk("ovf_wrcnt", WRCNT, DEPTH);
    cycle(1'b0, 1'b0, '0);

    // Drain back-to-back; model expects 1..128 on consecutive DVLD cycles.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0);
    repeat (3) cycle(1'b0, 1'b0, '0);
    chk("drain_empty", EMPTY, 1'b1);

    // Refill, then simultaneous push/pop while full.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, $urandom);
    cycle(1'b1, 1'b1, 32'h1234_5678);
    chk("full_rw_ovf",   OVERFLOW, 1'b1);
    chk("full_rw_wrcnt", WRCNT, DEPTH - 1);
    chk("full_rw_full",  FULL, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0);
    repeat (3) cycle(1'b0, 1'b0, '0);

    // Simultaneous push/pop while empty: no write-through.
    cycle(1'b1, 1'b1, 32'hA5A5_A5A5);
    chk("empty_rw_udf",   UNDERFLOW, 1'b1);
    chk("empty_rw_wrcnt", WRCNT, 1);
    cycle(1'b0, 1'b1, '0);
    repeat (3) cycle(1'b0, 1'b0, '0);

    // Pointer wrap with random data.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, $urandom);
      for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, '0);
    end
    repeat (3) cycle(1'b0, 1'b0, '0);

    // Random traffic, alternating push-heavy and pop-heavy phases.
    for (int i = 0; i < 1200; i++) begin
      if (((i / 150) % 2) == 0)
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom);
      else
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom);
    end

    // Reset with a pop in flight.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, $urandom);
    cycle(1'b0, 1'b1, '0);
    WE = 1'b0;
    RE = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_dvld",  DVLD,  1'b0);
    chk("midrst_empty", EMPTY, 1'b1);
    chk("midrst_wrcnt", WRCNT, 0);
    model_clear();
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK) RESET_N = 1'b1;
    @(posedge CLOCK);
    cyc++;
    #1;
    repeat (4) cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, $urandom);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, '0);
    repeat (3) cycle(1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
- Single-clock FIFO controller that drives the write and read address/enable side of the FIFO's LSRAM wrapper.
- Accepts user push/pop requests, maintains the pointers and occupancy count, and generates the status flags.
- Returns RAM read data to the user with a data-valid strobe that is aligned to the RAM read latency.
- Sits between user logic and the RAM wrapper; the RAM wrapper runs in single-clock mode on the same CLOCK.

Parameters:
- WIDTH, 32: data width; must equal the RAM wrapper's RWIDTH and WWIDTH.
- DEPTH, 128: number of entries; must be a power of 2, minimum 4.
- AW, clog2(DEPTH): RAM address width; derived, not to be overridden.
- PIPE, 1: RAM read pipeline. RAM read latency is 1+PIPE cycles; PIPE takes the value 0 or 1.
- AFULL_VAL, 120: AFULL asserts when count >= AFULL_VAL.
- AEMPTY_VAL, 8: AEMPTY asserts when count <= AEMPTY_VAL.

Ports:
- CLOCK  in  1  single clock; rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- WE  in  1  push request.
- DATA  in  WIDTH  push data.
- RE  in  1  pop request.
- Q  out  WIDTH  pop data; equal to RAM_RDATA.
- DVLD  out  1  Q valid strobe.
- FULL  out  1  FIFO full.
- EMPTY  out  1  FIFO empty.
- AFULL  out  1  almost full.
- AEMPTY  out  1  almost empty.
- OVERFLOW  out  1  one-cycle pulse: push rejected.
- UNDERFLOW  out  1  one-cycle pulse: pop rejected.
- WRCNT  out  AW+1  occupancy count, 0..DEPTH.
- RAM_WDATA  out  WIDTH  data to RAM WDATA.
- RAM_WADDR  out  AW  RAM write address.
- RAM_WEN  out  1  RAM write enable.
- RAM_RADDR  out  AW  RAM read address.
- RAM_REN  out  1  RAM read enable.
- RAM_RDATA  in  WIDTH  RAM read data.

Behaviour:
- Reset values:
  - Pointers and count are 0.
  - EMPTY=1, AEMPTY=1.
  - FULL=0, AFULL=0, OVERFLOW=0, UNDERFLOW=0, DVLD=0, WRCNT=0.
  - The DVLD delay line is cleared.
- Reset mid-operation discards all contents and clears in-flight reads; DVLD is forced to 0 immediately.
- Push accept:
  - wr_acc = WE & ~FULL.
  - RAM_WEN = wr_acc (combinational), RAM_WADDR = wptr[AW-1:0], RAM_WDATA = DATA.
  - On accept, wptr increments by 1.
- Pop accept:
  - rd_acc = RE & ~EMPTY.
  - RAM_REN = rd_acc (combinational), RAM_RADDR = rptr[AW-1:0].
  - On accept, rptr increments by 1.
- Pointers are AW+1 bits with a wrap bit. Address DEPTH-1 is followed by address 0, and the wrap bit toggles.
- Count update:
  - count_next = count + wr_acc - rd_acc.
  - WRCNT = count (registered).
- Flags are registered from count_next, so each flag is valid in the cycle after the access:
  - FULL = (count_next == DEPTH).
  - EMPTY = (count_next == 0).
  - AFULL = (count_next >= AFULL_VAL).
  - AEMPTY = (count_next <= AEMPTY_VAL).
- Simultaneous WE and RE:
  - Not full and not empty: both are accepted; count and flags are unchanged.
  - When FULL=1: the pop is accepted and the push is rejected (OVERFLOW pulses). The next cycle has FULL=0 and count=DEPTH-1.
  - When EMPTY=1: the push is accepted and the pop is rejected (UNDERFLOW pulses); there is no write-through. The next cycle has EMPTY=0.
- OVERFLOW is registered as WE & FULL; UNDERFLOW is registered as RE & EMPTY. Each pulses for 1 cycle per rejected request.
- Read data latency:
  - DVLD is rd_acc delayed by 1+PIPE cycles through a shift register.
  - Q = RAM_RDATA and is valid only while DVLD=1.
  - With PIPE=1, a pop in cycle N gives DVLD=1 and Q=data in cycle N+2.
- Back-to-back pops every cycle yield DVLD asserted on consecutive cycles, with no bubbles.
- A write followed by a read of the same address is safe: a push in cycle N makes EMPTY=0 in N+1, so the earliest pop is in N+1, after the RAM write is committed.

Decomposition:
- Package fifo_pkg holds:
  - the clog2 constant function;
  - the pointer/count width rule (AW+1);
  - the legal PIPE range check.
- One sub-module, fifo_rd_vld_pipe: a parameterised depth-(1+PIPE) shift register with asynchronous clear, producing DVLD from rd_acc.
- Pointer, count and flag logic stay in fifo_sync_ctrl.

Test Plan:
- Reset with WE=RE=0 -> EMPTY=1, AEMPTY=1, FULL=0, WRCNT=0, DVLD=0, RAM_WEN=RAM_REN=0.
- Push 0x00000001..0x00000080 (128 words) on consecutive cycles -> FULL=1 after the last push; AFULL=1 from count 120; WRCNT=128. A 129th push gives an OVERFLOW pulse, and WRCNT stays 128.
- Pop 128 words back-to-back with PIPE=1 -> DVLD high for 128 consecutive cycles starting 2 cycles after the first pop; Q = 0x00000001..0x00000080 in order; EMPTY=1 afterwards.
- While full, assert WE and RE together -> the pop is accepted, the push is rejected, OVERFLOW pulses, WRCNT=127, FULL=0.
- While empty, assert WE and RE together with DATA=0xA5A5A5A5 -> UNDERFLOW pulses, WRCNT=1, no DVLD. The next pop returns Q=0xA5A5A5A5.
- Wrap and reset:
  - Push 100 / pop 100 three times -> pointers wrap past 127, and data integrity holds.
  - Assert RESET_N=0 with a pop in flight -> DVLD=0 immediately, EMPTY=1, WRCNT=0.
